// File: rtl/uart_rx_if.sv
// Byte-delivery bus of the UART receiver: valid/ready data path plus error pulses.
// The receiver drives through the master modport; the consumer uses the slave modport.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, one-entry valid/ready output register.
// Optional feature: define UART_RX_MAJORITY_EN for 3-sample majority voting at every sample point.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 2813,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t HALF_LAST = cnt_t'(HALF_BIT - 1);
  localparam cnt_t BIT_LAST  = cnt_t'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic       rx_meta_q;
  logic       rx_s_q;
  state_e     state_q,     state_d;
  cnt_t       cnt_q,       cnt_d;
  logic [2:0] idx_q,       idx_d;
  logic [7:0] shift_q,     shift_d;
  logic [7:0] data_q,      data_d;
  logic       valid_q,     valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q,   overrun_d;
  logic       sample;
  logic       accept;

  // Two-flop synchroniser; idle-high reset so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep both flops sampling the pre-edge values,
      // so the chain really is two stages deep rather than collapsing to one.
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Window of rx_s at cnt = target-2, target-1 (history) and target (current).
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign sample = (hist_q[1] & hist_q[0]) |
                  (hist_q[1] & rx_s_q)    |
                  (hist_q[0] & rx_s_q);
`else
  assign sample = rx_s_q;
`endif

  assign accept = valid_q & bus.rx_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q & ~accept;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = sample ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (!sample) begin
            frame_err_d = 1'b1;
          end else if (!valid_q || accept) begin
            // A byte landing in the same cycle as a handshake replaces it without loss.
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the shift register is deliberately left out of reset: every bit is
  // overwritten by a full frame before it can reach rx_data.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus a randomized frame stream
// compared against a queue-based expectation of delivered bytes and error pulses.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;

  // Consumer-side monitor: records every handshaken byte and every pulse cycle.
  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_ready) got_q.push_back(bus.rx_data);
    if (bus.frame_err) fe_cnt++;
    if (bus.overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return {24'h0, got_q[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  int         lat;
  logic [7:0] lat_data;
  int         fe0, ov0;
  logic [7:0] c6;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_ready = 1'b0;
    idle(3);
    @(negedge clk);
    check("rst_data",      bus.rx_data,   32'h00);
    check("rst_valid",     bus.rx_valid,  32'h0);
    check("rst_frame_err", bus.rx_valid & 1'b0 | bus.frame_err, 32'h0);
    check("rst_overrun",   bus.overrun,   32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);

    // Latency and data of 0x55, counted from the pin's falling edge.
    bus.rx_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    lat = 0; lat_data = 8'h00;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(posedge clk);
          @(negedge clk);
          if (bus.rx_valid) begin
            lat      = k;
            lat_data = bus.rx_data;
            break;
          end
        end
      end
    join
    idle(4);
    check("lat_cycles", lat,      3 + HALF + 9 * CPB);
    check("lat_data",   lat_data, 32'h55);
    check("lat_fe",     fe_cnt - fe0, 0);
    check("lat_ov",     ov_cnt - ov0, 0);

    // Back-to-back frames with ready held high.
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle(8);
    check("b2b_count", got_q.size(), 2);
    check("b2b_0",     got_at(0),    32'hA3);
    check("b2b_1",     got_at(1),    32'h0F);
    check("b2b_err",   (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    // Overrun: second byte arrives while the first is still held.
    bus.rx_ready = 1'b0;
    got_q.delete();
    ov0 = ov_cnt;
    send_frame(8'h12, 1'b1);
    idle(4);
    @(negedge clk);
    check("ovr_valid1", bus.rx_valid, 32'h1);
    check("ovr_data1",  bus.rx_data,  32'h12);
    @(posedge clk); #1;
    send_frame(8'h34, 1'b1);
    idle(4);
    @(negedge clk);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_data2",  bus.rx_data,  32'h12);
    check("ovr_valid2", bus.rx_valid, 32'h1);
    @(posedge clk); #1;
    bus.rx_ready = 1'b1;
    @(posedge clk); #1;
    bus.rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_valid3", bus.rx_valid,  32'h0);
    check("ovr_count",  got_q.size(),  1);
    check("ovr_byte",   got_at(0),     32'h12);
    @(posedge clk); #1;

    // Framing error followed by a good frame.
    bus.rx_ready = 1'b1;
    got_q.delete();
    fe0 = fe_cnt;
    send_frame(8'h7E, 1'b0);
    idle(2 * CPB);
    @(negedge clk);
    check("fe_pulses", fe_cnt - fe0, 1);
    check("fe_valid",  bus.rx_valid, 32'h0);
    check("fe_none",   got_q.size(), 0);
    @(posedge clk); #1;
    send_frame(8'h81, 1'b1);
    idle(4);
    check("fe_next_count", got_q.size(), 1);
    check("fe_next_byte",  got_at(0),    32'h81);

    // Short low glitch on the idle line must be rejected as a false start.
    got_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(3 * CPB);
    check("glitch_none", got_q.size(), 0);
    check("glitch_err",  (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    send_frame(8'h96, 1'b1);
    idle(4);
    check("glitch_next", got_at(0), 32'h96);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle glitch exactly at the mid-bit of data bit 3 of 0xFF.
    got_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx = 1'b1;
    idle(HALF);
    rx = 1'b0;
    idle(1);
    rx = 1'b1;
    idle(CPB - HALF - 1);
    for (int i = 4; i < 8; i++) drive_bit(1'b1);
    drive_bit(1'b1);
    idle(4);
    check("maj_byte", got_at(0), 32'hFF);
`endif

    // Reset during data bit 4, with a held byte present beforehand.
    bus.rx_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    idle(4);
    @(negedge clk);
    check("rstm_pre_valid", bus.rx_valid, 32'h1);
    @(posedge clk); #1;
    c6 = 8'hC6;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c6[i]);
    rx = c6[4];
    idle(HALF);
    rst_n = 1'b0;
    rx    = 1'b1;
    idle(2);
    @(negedge clk);
    check("rstm_data",  bus.rx_data,   32'h00);
    check("rstm_valid", bus.rx_valid,  32'h0);
    check("rstm_fe",    bus.frame_err, 32'h0);
    check("rstm_ov",    bus.overrun,   32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3 * CPB);
    @(negedge clk);
    check("rstm_quiet", bus.rx_valid, 32'h0);
    @(posedge clk); #1;
    bus.rx_ready = 1'b1;
    got_q.delete();
    send_frame(8'h3C, 1'b1);
    idle(4);
    check("rstm_next_count", got_q.size(), 1);
    check("rstm_next_byte",  got_at(0),    32'h3C);

    // Randomized stream: good frames must arrive in order, bad stops only pulse frame_err.
    got_q.delete();
    exp_q.delete();
    fe0 = fe_cnt; ov0 = ov_cnt;
    begin
      int exp_fe;
      exp_fe = 0;
      for (int n = 0; n < 24; n++) begin
        logic [7:0] b;
        logic       stop;
        b    = 8'($urandom);
        stop = ($urandom_range(0, 5) != 0);
        send_frame(b, stop);
        if (stop) begin
          exp_q.push_back(b);
          idle($urandom_range(0, 20));
        end else begin
          exp_fe++;
          idle(2 * CPB + $urandom_range(0, 8));
        end
      end
      idle(4);
      check("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("rand_byte%0d", i), got_at(i), {24'h0, exp_q[i]});
      end
      check("rand_fe", fe_cnt - fe0, exp_fe);
      check("rand_ov", ov_cnt - ov0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
